wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone classic bus initiator. It converts a valid/ready command stream (one read or write per command) into single Wishbone cycles.
- Handles wait states, rty-driven retries and a bus timeout.
- Returns one response (read data + status) per command on a valid/ready response stream.
- Sits between a local controller (CSR engine, DMA sequencer) and a Wishbone interconnect or register slice.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64)
- ADDR_WIDTH, 32, address bus width in bits
- SELECT_WIDTH, DATA_WIDTH/8, byte select width
- TIMEOUT, 256, max cycles stb held per attempt with no termination; 0 disables timeout
- RETRY_MAX, 3, max re-issues after rty before giving up

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_addr  in  ADDR_WIDTH  command address
- cmd_data  in  DATA_WIDTH  write data
- cmd_we  in  1  1=write, 0=read
- cmd_sel  in  SELECT_WIDTH  byte selects
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and for failed reads
- rsp_status  out  2  00 ok, 01 err, 10 retry exhausted, 11 timeout
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- busy  out  1  high in any state other than IDLE
- m_adr_o  out  ADDR_WIDTH  Wishbone ADR_O
- m_dat_i  in  DATA_WIDTH  Wishbone DAT_I
- m_dat_o  out  DATA_WIDTH  Wishbone DAT_O
- m_we_o  out  1  Wishbone WE_O
- m_sel_o  out  SELECT_WIDTH  Wishbone SEL_O
- m_stb_o  out  1  Wishbone STB_O
- m_ack_i  in  1  Wishbone ACK_I
- m_err_i  in  1  Wishbone ERR_I
- m_rty_i  in  1  Wishbone RTY_I
- m_cyc_o  out  1  Wishbone CYC_O

Behaviour:

Reset:
- Reset values: every output 0 except cmd_ready, which is 0 during the reset cycle and 1 on the cycle after reset deasserts.
- State after reset: IDLE; retry and timeout counters cleared.
- Reset asserted in any state: cyc/stb/we low after that edge. The in-flight command is discarded and no response is produced.

Registering and FSM:
- All Wishbone outputs are driven from registers.
- States: IDLE, BUS, BACKOFF, RESP.

IDLE:
- cmd_ready=1.
- On cmd_valid&cmd_ready at edge N: latch addr/data/we/sel, clear counters, go to BUS.
- From cycle N+1: m_cyc_o=m_stb_o=1 and m_we_o=latched we.

BUS:
- cmd_ready=0.
- adr/dat/sel/we are held stable for the whole command, including across retries.
- Termination inputs are sampled each edge. Priority when several are asserted together: ack > err > rty.
- ack: rsp_data<=m_dat_i for reads, 0 for writes; status 00; go to RESP.
- err: rsp_data 0; status 01; go to RESP.
- rty with retry_cnt<RETRY_MAX: retry_cnt+1, go to BACKOFF.
- rty with retry_cnt==RETRY_MAX: rsp_data 0; status 10; go to RESP.
- Timeout (TIMEOUT!=0): the counter increments each BUS cycle with no termination. When it reaches TIMEOUT-1 without termination, status 11 and go to RESP, so stb is high exactly TIMEOUT cycles.
- Any exit from BUS: m_cyc_o, m_stb_o and m_we_o go low on the same edge.

BACKOFF:
- cyc/stb low for exactly one cycle.
- Timeout counter cleared, then return to BUS with cyc/stb high again.
- Termination inputs are ignored here.

RESP:
- rsp_valid=1; rsp_data and rsp_status held stable until rsp_valid&rsp_ready.
- On the handshake edge: go to IDLE; rsp_valid low and cmd_ready high on the next cycle.
- Only one command is outstanding at a time.

Timing and boundary rules:
- Latency with a zero-wait slave (ack in the first stb cycle): cmd accepted at edge N; cyc high in cycle N+1 only; rsp_valid high from cycle N+2.
- Each added wait state adds one cycle.
- Each retry adds BACKOFF (1 cycle) plus the new attempt.
- Termination inputs asserted while stb is low (IDLE/BACKOFF/RESP) are ignored.
- RETRY_MAX=0: the first rty ends the command with status 10.
- Counter widths: retry counter $clog2(RETRY_MAX+1); timeout counter $clog2(TIMEOUT+1). Minimum width 1 for each. No wrap is possible.

Test Plan:
1. Read, addr 0x10, slave acks in first stb cycle with 0xDEADBEEF -> cyc/stb high exactly 1 cycle; rsp_valid 2 cycles after accept; rsp_data 0xDEADBEEF; status 00.
2. Write, addr 0x20, data 0x12345678, sel 0x3, slave inserts 3 wait states -> cyc high 4 cycles; adr/dat/sel/we stable throughout; status 00; rsp_data 0.
3. RETRY_MAX=3, slave answers rty, rty, then ack with 0xA5A5A5A5 -> three stb pulses separated by 1-cycle low gaps; status 00; rsp_data 0xA5A5A5A5.
4. RETRY_MAX=3, slave always rty -> exactly 4 stb attempts; status 10; rsp_data 0. Separately, ack+err asserted together -> status 00.
5. TIMEOUT=16, slave silent -> stb high exactly 16 cycles then low; status 11. Separately, TIMEOUT=0 with slave silent 1000 cycles -> stb still high.
6. rsp_ready held low 5 cycles -> rsp_valid/data/status stable; cmd_ready low; cmd_valid not accepted. Separately, rst pulsed mid-BUS -> cyc/stb low after that edge; no rsp_valid; cmd_ready=1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: turns a valid/ready command stream into single
// Wishbone cycles with retry, timeout and one response per command.
module wb_cmd_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 256,
  parameter int RETRY_MAX    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_we,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   m_adr_o,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  output logic                    m_we_o,
  output logic [SELECT_WIDTH-1:0] m_sel_o,
  output logic                    m_stb_o,
  input  logic                    m_ack_i,
  input  logic                    m_err_i,
  input  logic                    m_rty_i,
  output logic                    m_cyc_o
);

  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);
  localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_RETRY   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

  state_t        state;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] to_cnt;
  logic          we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      to_cnt     <= '0;
      we_q       <= 1'b0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= '0;
      rsp_valid  <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
      m_sel_o    <= '0;
      m_we_o     <= 1'b0;
      m_stb_o    <= 1'b0;
      m_cyc_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            m_adr_o   <= cmd_addr;
            m_dat_o   <= cmd_data;
            m_sel_o   <= cmd_sel;
            we_q      <= cmd_we;
            m_we_o    <= cmd_we;
            m_cyc_o   <= 1'b1;
            m_stb_o   <= 1'b1;
            retry_cnt <= '0;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= BUS;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        // ack > err > rty > timeout; every exit drops cyc/stb/we on this edge
        BUS: begin
          if (m_ack_i) begin
            rsp_data   <= we_q ? '0 : m_dat_i;
            rsp_status <= ST_OK;
            rsp_valid  <= 1'b1;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            state      <= RESP;
          end else if (m_err_i) begin
            rsp_data   <= '0;
            rsp_status <= ST_ERR;
            rsp_valid  <= 1'b1;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            state      <= RESP;
          end else if (m_rty_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            if (retry_cnt == RETRY_LAST) begin
              rsp_data   <= '0;
              rsp_status <= ST_RETRY;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= BACKOFF;
            end
          end else if (TIMEOUT != 0) begin
            if (to_cnt == TO_LAST) begin
              rsp_data   <= '0;
              rsp_status <= ST_TIMEOUT;
              rsp_valid  <= 1'b1;
              m_cyc_o    <= 1'b0;
              m_stb_o    <= 1'b0;
              m_we_o     <= 1'b0;
              state      <= RESP;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end

        BACKOFF: begin
          to_cnt  <= '0;
          m_cyc_o <= 1'b1;
          m_stb_o <= 1'b1;
          m_we_o  <= we_q;
          state   <= BUS;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master: one DUT with TIMEOUT=16,
// RETRY_MAX=3 and one with TIMEOUT=0, RETRY_MAX=0.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_addr, cmd_data, m_dat_i;
  logic        cmd_we, cmd_valid, z_cmd_valid, rsp_ready;
  logic [3:0]  cmd_sel;
  logic        m_ack_i, m_err_i, m_rty_i;

  logic        cmd_ready, rsp_valid, busy, m_we_o, m_stb_o, m_cyc_o;
  logic [31:0] rsp_data, m_adr_o, m_dat_o;
  logic [1:0]  rsp_status;
  logic [3:0]  m_sel_o;

  logic        z_cmd_ready, z_rsp_valid, z_busy, z_m_we_o, z_m_stb_o, z_m_cyc_o;
  logic [31:0] z_rsp_data, z_m_adr_o, z_m_dat_o;
  logic [1:0]  z_rsp_status;
  logic [3:0]  z_m_sel_o;

  int unsigned chk = 0;
  int unsigned pass = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16), .RETRY_MAX(3)) dut (
    .clk(clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy),
    .m_adr_o(m_adr_o), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .m_rty_i(m_rty_i), .m_cyc_o(m_cyc_o)
  );

  wb_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(0), .RETRY_MAX(0)) dut_z (
    .clk(clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .rsp_data(z_rsp_data),
    .rsp_status(z_rsp_status), .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .busy(z_busy),
    .m_adr_o(z_m_adr_o), .m_dat_i(m_dat_i), .m_dat_o(z_m_dat_o), .m_we_o(z_m_we_o),
    .m_sel_o(z_m_sel_o), .m_stb_o(z_m_stb_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .m_rty_i(m_rty_i), .m_cyc_o(z_m_cyc_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [3:0] sel, input logic to_z);
    cmd_addr = a; cmd_data = d; cmd_we = we; cmd_sel = sel;
    if (to_z) z_cmd_valid = 1'b1; else cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0; z_cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    chk++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); else pass++;
    chk++; if ({m_cyc_o, m_stb_o, m_we_o, rsp_valid, busy} !== 5'b0)
      $display("FAIL rst_ctrl: got %b want 00000", {m_cyc_o, m_stb_o, m_we_o, rsp_valid, busy}); else pass++;
    chk++; if ({rsp_data, rsp_status, m_adr_o, m_dat_o, m_sel_o} !== 102'b0)
      $display("FAIL rst_data: got %h want 0", {rsp_data, rsp_status, m_adr_o, m_dat_o, m_sel_o}); else pass++;
    rst = 1'b0;
    tick;
    chk++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", cmd_ready); else pass++;
    chk++; if (z_cmd_ready !== 1'b1) $display("FAIL rst_release_ready_z: got %b want 1", z_cmd_ready); else pass++;
  endtask

  task automatic test_read_zero_wait;
    issue(32'h10, 32'h0, 1'b0, 4'hF, 1'b0);
    chk++; if ({m_cyc_o, m_stb_o, m_we_o, cmd_ready, busy, rsp_valid} !== 6'b110010)
      $display("FAIL rd_bus: got %b want 110010", {m_cyc_o, m_stb_o, m_we_o, cmd_ready, busy, rsp_valid}); else pass++;
    chk++; if (m_adr_o !== 32'h10) $display("FAIL rd_adr: got %h want 00000010", m_adr_o); else pass++;
    m_ack_i = 1'b1; m_dat_i = 32'hDEADBEEF;
    tick;
    m_ack_i = 1'b0; m_dat_i = 32'h0;
    chk++; if ({m_cyc_o, m_stb_o, rsp_valid} !== 3'b001)
      $display("FAIL rd_resp_ctrl: got %b want 001", {m_cyc_o, m_stb_o, rsp_valid}); else pass++;
    chk++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rsp_data); else pass++;
    chk++; if (rsp_status !== 2'b00) $display("FAIL rd_status: got %b want 00", rsp_status); else pass++;
    tick;
    chk++; if ({rsp_valid, cmd_ready, busy} !== 3'b010)
      $display("FAIL rd_done: got %b want 010", {rsp_valid, cmd_ready, busy}); else pass++;
  endtask

  task automatic test_write_wait_states;
    int unsigned cyc_n = 0;
    issue(32'h20, 32'h12345678, 1'b1, 4'h3, 1'b0);
    m_dat_i = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      if (m_cyc_o) cyc_n++;
      chk++; if ({m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o} !== {2'b11, 32'h20, 32'h12345678, 4'h3})
        $display("FAIL wr_stable[%0d]: got %b %b %h %h %h want 1 1 00000020 12345678 3",
                 i, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o); else pass++;
      if (i == 3) m_ack_i = 1'b1;
      tick;
    end
    m_ack_i = 1'b0;
    chk++; if (cyc_n !== 4) $display("FAIL wr_cyc_len: got %0d want 4", cyc_n); else pass++;
    chk++; if ({m_cyc_o, m_we_o, rsp_valid, rsp_status} !== 5'b00100)
      $display("FAIL wr_resp: got %b want 00100", {m_cyc_o, m_we_o, rsp_valid, rsp_status}); else pass++;
    chk++; if (rsp_data !== 32'h0) $display("FAIL wr_data: got %h want 00000000", rsp_data); else pass++;
    tick;
  endtask

  task automatic test_retry_then_ack;
    int unsigned pulses = 0;
    issue(32'h30, 32'h0, 1'b0, 4'hF, 1'b0);
    for (int a = 0; a < 3; a++) begin
      m_ack_i = 1'b0;
      if (m_stb_o) pulses++;
      chk++; if (m_adr_o !== 32'h30) $display("FAIL rty_adr[%0d]: got %h want 00000030", a, m_adr_o); else pass++;
      if (a < 2) m_rty_i = 1'b1;
      else begin m_ack_i = 1'b1; m_dat_i = 32'hA5A5A5A5; end
      tick;
      m_rty_i = 1'b0; m_ack_i = 1'b0; m_dat_i = 32'h0;
      if (a < 2) begin
        chk++; if ({m_cyc_o, m_stb_o, rsp_valid} !== 3'b000)
          $display("FAIL rty_gap[%0d]: got %b want 000", a, {m_cyc_o, m_stb_o, rsp_valid}); else pass++;
        // an ack while stb is low must be ignored
        if (a == 0) begin m_ack_i = 1'b1; m_dat_i = 32'h77777777; end
        tick;
      end
    end
    chk++; if (pulses !== 3) $display("FAIL rty_pulses: got %0d want 3", pulses); else pass++;
    chk++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b00, 32'hA5A5A5A5})
      $display("FAIL rty_resp: got %b %b %h want 1 00 a5a5a5a5", rsp_valid, rsp_status, rsp_data); else pass++;
    tick;
  endtask

  task automatic test_retry_exhausted;
    int unsigned pulses = 0;
    int unsigned n = 0;
    issue(32'h34, 32'h0, 1'b0, 4'hF, 1'b0);
    m_rty_i = 1'b1; m_dat_i = 32'h55555555;
    while (!rsp_valid && n < 20) begin
      if (m_stb_o) pulses++;
      n++;
      tick;
    end
    m_rty_i = 1'b0; m_dat_i = 32'h0;
    chk++; if (pulses !== 4) $display("FAIL rtyx_attempts: got %0d want 4", pulses); else pass++;
    chk++; if (n !== 7) $display("FAIL rtyx_cycles: got %0d want 7", n); else pass++;
    chk++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b10, 32'h0})
      $display("FAIL rtyx_resp: got %b %b %h want 1 10 00000000", rsp_valid, rsp_status, rsp_data); else pass++;
    tick;
  endtask

  task automatic test_priority;
    logic [2:0]  terms [3]    = '{3'b110, 3'b010, 3'b011};
    logic [1:0]  exp_st [3]   = '{2'b00, 2'b01, 2'b01};
    logic [31:0] exp_dat [3]  = '{32'h11223344, 32'h0, 32'h0};
    for (int k = 0; k < 3; k++) begin
      issue(32'h50, 32'h0, 1'b0, 4'hF, 1'b0);
      {m_ack_i, m_err_i, m_rty_i} = terms[k]; m_dat_i = 32'h11223344;
      tick;
      {m_ack_i, m_err_i, m_rty_i} = 3'b000; m_dat_i = 32'h0;
      chk++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, exp_st[k], exp_dat[k]})
        $display("FAIL prio[%0d]: got %b %b %h want 1 %b %h", k, rsp_valid, rsp_status, rsp_data,
                 exp_st[k], exp_dat[k]); else pass++;
      tick;
    end
  endtask

  task automatic test_timeout;
    int unsigned n = 0;
    issue(32'h60, 32'h0, 1'b1, 4'hF, 1'b0);
    while (m_stb_o && n < 100) begin
      n++;
      tick;
    end
    chk++; if (n !== 16) $display("FAIL to_stb_len: got %0d want 16", n); else pass++;
    chk++; if ({m_cyc_o, rsp_valid, rsp_status} !== 4'b0111)
      $display("FAIL to_resp: got %b want 0111", {m_cyc_o, rsp_valid, rsp_status}); else pass++;
    tick;
  endtask

  task automatic test_no_timeout_and_zero_retry;
    int unsigned hi = 0;
    issue(32'h70, 32'h0, 1'b0, 4'hF, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      if (z_m_stb_o) hi++;
      tick;
    end
    chk++; if (hi !== 1000 || z_m_stb_o !== 1'b1)
      $display("FAIL nto_stb: got %0d cycles stb=%b want 1000 stb=1", hi, z_m_stb_o); else pass++;
    m_ack_i = 1'b1; m_dat_i = 32'h0BADF00D;
    tick;
    m_ack_i = 1'b0; m_dat_i = 32'h0;
    chk++; if ({z_rsp_valid, z_rsp_status, z_rsp_data} !== {1'b1, 2'b00, 32'h0BADF00D})
      $display("FAIL nto_resp: got %b %b %h want 1 00 0badf00d", z_rsp_valid, z_rsp_status, z_rsp_data); else pass++;
    tick;
    issue(32'h74, 32'h0, 1'b0, 4'hF, 1'b1);
    m_rty_i = 1'b1;
    tick;
    m_rty_i = 1'b0;
    chk++; if ({z_m_stb_o, z_rsp_valid, z_rsp_status} !== 4'b0110)
      $display("FAIL r0_resp: got %b want 0110", {z_m_stb_o, z_rsp_valid, z_rsp_status}); else pass++;
    tick;
    chk++; if (z_cmd_ready !== 1'b1) $display("FAIL r0_ready: got %b want 1", z_cmd_ready); else pass++;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    issue(32'h80, 32'h0, 1'b0, 4'hF, 1'b0);
    m_ack_i = 1'b1; m_dat_i = 32'hCAFEF00D;
    tick;
    m_ack_i = 1'b0; m_dat_i = 32'h0;
    cmd_addr = 32'h99; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk++; if ({rsp_valid, rsp_status, rsp_data, cmd_ready, m_cyc_o} !== {1'b1, 2'b00, 32'hCAFEF00D, 2'b00})
        $display("FAIL bp_hold[%0d]: got %b %b %h rdy=%b cyc=%b want 1 00 cafef00d 0 0",
                 i, rsp_valid, rsp_status, rsp_data, cmd_ready, m_cyc_o); else pass++;
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    chk++; if ({rsp_valid, cmd_ready, m_cyc_o} !== 3'b010)
      $display("FAIL bp_release: got %b want 010", {rsp_valid, cmd_ready, m_cyc_o}); else pass++;
    tick;
    chk++; if ({m_cyc_o, busy} !== 2'b00)
      $display("FAIL bp_no_accept: got %b want 00", {m_cyc_o, busy}); else pass++;
  endtask

  task automatic test_reset_mid_bus;
    issue(32'h40, 32'hAAAA5555, 1'b1, 4'hF, 1'b0);
    tick; tick;
    rst = 1'b1;
    tick;
    chk++; if ({m_cyc_o, m_stb_o, m_we_o, rsp_valid, cmd_ready} !== 5'b0)
      $display("FAIL rstbus_low: got %b want 00000", {m_cyc_o, m_stb_o, m_we_o, rsp_valid, cmd_ready}); else pass++;
    rst = 1'b0;
    tick;
    chk++; if ({cmd_ready, rsp_valid, busy, m_cyc_o} !== 4'b1000)
      $display("FAIL rstbus_after: got %b want 1000", {cmd_ready, rsp_valid, busy, m_cyc_o}); else pass++;
    m_ack_i = 1'b1; m_err_i = 1'b1;
    tick; tick;
    m_ack_i = 1'b0; m_err_i = 1'b0;
    chk++; if ({rsp_valid, busy, m_cyc_o, cmd_ready} !== 4'b0001)
      $display("FAIL idle_ignore: got %b want 0001", {rsp_valid, busy, m_cyc_o, cmd_ready}); else pass++;
  endtask

  initial begin
    rst = 1'b1; cmd_addr = '0; cmd_data = '0; cmd_we = 1'b0; cmd_sel = '0;
    cmd_valid = 1'b0; z_cmd_valid = 1'b0; rsp_ready = 1'b1; m_dat_i = '0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
    #1;
    test_reset;
    test_read_zero_wait;
    test_write_wait_states;
    test_retry_then_ack;
    test_retry_exhausted;
    test_priority;
    test_timeout;
    test_no_timeout_and_zero_retry;
    test_backpressure;
    test_reset_mid_bus;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
